caliptra_tlul_host_arb: RTL and testbench

- Round-robin arbiter that shares one TL-UL device port among NumHosts TL-UL hosts.
- Typical device: the register-interface adapter in a reg_top.
- Exactly one transaction is in flight at a time, matching the device's single-outstanding behaviour.
- Sits between the crossbar/host ports and the device; routes the D-channel response back to the granted host.

---
 rtl/caliptra_tlul_pkg.sv | 53 +++++
 rtl/caliptra_tlul_host_arb_if.sv | 26 ++
 rtl/caliptra_tlul_rr_pick.sv | 32 +++
 rtl/caliptra_tlul_host_arb.sv | 137 +++++++++++++
 tb/tb_caliptra_tlul_host_arb.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/caliptra_tlul_pkg.sv
// TL-UL payload types, idle drive values and arbiter state encoding.
package caliptra_tlul_pkg;

  localparam int unsigned TlAw     = 32;
  localparam int unsigned TlDw     = 32;
  localparam int unsigned TlMaskW  = TlDw / 8;
  localparam int unsigned TlAiw    = 8;
  localparam int unsigned TlDiw    = 1;
  localparam int unsigned TlSzw    = 2;
  localparam int unsigned TlUserW  = 7;

  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  typedef struct packed {
    logic                a_valid;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [TlSzw-1:0]    a_size;
    logic [TlAiw-1:0]    a_source;
    logic [TlAw-1:0]     a_address;
    logic [TlMaskW-1:0]  a_mask;
    logic [TlDw-1:0]     a_data;
    logic [TlUserW-1:0]  a_user;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    logic [2:0]          d_opcode;
    logic [2:0]          d_param;
    logic [TlSzw-1:0]    d_size;
    logic [TlAiw-1:0]    d_source;
    logic [TlDiw-1:0]    d_sink;
    logic [TlDw-1:0]     d_data;
    logic [TlUserW-1:0]  d_user;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  // Idle drive values: no valid, no ready on either channel.
  localparam tl_h2d_t TL_H2D_DEFAULT = '0;
  localparam tl_d2h_t TL_D2H_DEFAULT = '0;

  typedef enum logic [1:0] {
    ArbIdle = 2'd0,
    ArbHold = 2'd1,
    ArbRsp  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/caliptra_tlul_host_arb_if.sv
// Host-side and device-side TL-UL links of the host arbiter.
// slave: arbiter view; master: environment (hosts + device) view.
interface caliptra_tlul_host_arb_if #(
  parameter int unsigned NumHosts = 2
);
  import caliptra_tlul_pkg::*;

  tl_h2d_t [NumHosts-1:0] tl_h_i;
  tl_d2h_t [NumHosts-1:0] tl_h_o;
  tl_h2d_t                tl_d_o;
  tl_d2h_t                tl_d_i;

  modport slave (
    input  tl_h_i,
    input  tl_d_i,
    output tl_h_o,
    output tl_d_o
  );

  modport master (
    output tl_h_i,
    output tl_d_i,
    input  tl_h_o,
    input  tl_d_o
  );
endinterface

// File: rtl/caliptra_tlul_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping.
module caliptra_tlul_rr_pick #(
  parameter  int unsigned NumHosts = 2,
  localparam int unsigned HostIdxW = $clog2(NumHosts)
) (
  input  logic [NumHosts-1:0] i_req,
  input  logic [HostIdxW-1:0] i_last,
  output logic [HostIdxW-1:0] o_idx,
  output logic                o_any
);

  function automatic logic [HostIdxW-1:0] wrap_idx(input logic [HostIdxW-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NumHosts) sum = sum - NumHosts;
    return HostIdxW'(sum);
  endfunction

  // Scan from farthest to nearest so the nearest requester after i_last wins.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = int'(NumHosts); k > 0; k--) begin
      if (i_req[wrap_idx(i_last, unsigned'(k))]) begin
        o_idx = wrap_idx(i_last, unsigned'(k));
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/caliptra_tlul_host_arb.sv
// Round-robin arbiter sharing one single-outstanding TL-UL device among hosts.
// Optional per-host grant counters: define CALIPTRA_TLUL_HOST_ARB_GNT_CNT_EN.
module caliptra_tlul_host_arb
  import caliptra_tlul_pkg::*;
#(
  parameter  int unsigned NumHosts = 2,
  parameter  int unsigned CntW     = 16,
  localparam int unsigned HostIdxW = $clog2(NumHosts)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  caliptra_tlul_host_arb_if.slave          tl_bus,
  output logic [HostIdxW-1:0]              gnt_idx_o,
  output logic                             busy_o,
  output logic                             proto_err_o,
  output logic [NumHosts-1:0][CntW-1:0]    gnt_cnt_o
);

  arb_state_e             r_state, w_state_nxt;
  logic [HostIdxW-1:0]    r_gnt, w_gnt_nxt;
  logic [HostIdxW-1:0]    r_last, w_last_nxt;
  logic                   r_proto_err, w_proto_err;
  logic [NumHosts-1:0]    w_req;
  logic [HostIdxW-1:0]    w_pick;
  logic                   w_any;
  tl_h2d_t                w_tl_d_o;
  tl_d2h_t [NumHosts-1:0] w_tl_h_o;

  // Gather host A-channel valids for the picker.
  always_comb begin
    for (int i = 0; i < int'(NumHosts); i++) w_req[i] = tl_bus.tl_h_i[i].a_valid;
  end

  caliptra_tlul_rr_pick #(.NumHosts(NumHosts)) u_pick (
    .i_req  (w_req),
    .i_last (r_last),
    .o_idx  (w_pick),
    .o_any  (w_any)
  );

  // State, grant and last-winner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ArbIdle;
      r_gnt       <= '0;
      r_last      <= HostIdxW'(NumHosts - 1);
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_last      <= w_last_nxt;
      r_proto_err <= w_proto_err;
    end
  end

  // Next state and channel routing; everything idles while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_proto_err = 1'b0;
    w_tl_d_o    = TL_H2D_DEFAULT;
    for (int i = 0; i < int'(NumHosts); i++) w_tl_h_o[i] = TL_D2H_DEFAULT;
    if (!rst_i) begin
      unique case (r_state)
        ArbIdle: begin
          if (w_any) begin
            w_tl_d_o                 = tl_bus.tl_h_i[w_pick];
            w_tl_d_o.d_ready         = 1'b0;
            w_tl_h_o[w_pick].a_ready = tl_bus.tl_d_i.a_ready;
            w_gnt_nxt                = w_pick;
            if (tl_bus.tl_d_i.a_ready) begin
              w_state_nxt = ArbRsp;
              w_last_nxt  = w_pick;
            end else begin
              w_state_nxt = ArbHold;
            end
          end
        end
        ArbHold: begin
          if (tl_bus.tl_h_i[r_gnt].a_valid) begin
            w_tl_d_o                = tl_bus.tl_h_i[r_gnt];
            w_tl_d_o.d_ready        = 1'b0;
            w_tl_h_o[r_gnt].a_ready = tl_bus.tl_d_i.a_ready;
            if (tl_bus.tl_d_i.a_ready) begin
              w_state_nxt = ArbRsp;
              w_last_nxt  = r_gnt;
            end
          end else begin
            w_state_nxt = ArbIdle;
            w_proto_err = 1'b1;
          end
        end
        ArbRsp: begin
          w_tl_h_o[r_gnt]         = tl_bus.tl_d_i;
          w_tl_h_o[r_gnt].a_ready = 1'b0;
          w_tl_d_o.d_ready        = tl_bus.tl_h_i[r_gnt].d_ready;
          if (tl_bus.tl_d_i.d_valid && tl_bus.tl_h_i[r_gnt].d_ready) begin
            w_state_nxt = ArbIdle;
          end
        end
        default: w_state_nxt = ArbIdle;
      endcase
    end
  end

  assign tl_bus.tl_d_o = w_tl_d_o;
  assign tl_bus.tl_h_o = w_tl_h_o;
  assign busy_o        = (r_state != ArbIdle);
  assign gnt_idx_o     = (r_state == ArbIdle) ? w_pick : r_gnt;
  assign proto_err_o   = r_proto_err;

`ifdef CALIPTRA_TLUL_HOST_ARB_GNT_CNT_EN
  logic [NumHosts-1:0][CntW-1:0] r_cnt;
  logic                          w_a_ack;

  assign w_a_ack = w_tl_d_o.a_valid & tl_bus.tl_d_i.a_ready;

  // Saturating count of accepted requests per host.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_a_ack) begin
      for (int i = 0; i < int'(NumHosts); i++) begin
        if (gnt_idx_o == HostIdxW'(i) && r_cnt[i] != {CntW{1'b1}}) begin
          r_cnt[i] <= r_cnt[i] + CntW'(1);
        end
      end
    end
  end

  assign gnt_cnt_o = r_cnt;
`else
  assign gnt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_caliptra_tlul_host_arb.sv
// Directed bench for the TL-UL host arbiter with three hosts.
module tb_caliptra_tlul_host_arb;
  import caliptra_tlul_pkg::*;

  localparam int unsigned NH   = 3;
  localparam int unsigned CW   = 16;
  localparam int unsigned IW   = $clog2(NH);

`ifdef CALIPTRA_TLUL_HOST_ARB_GNT_CNT_EN
  localparam logic [31:0] CNT_ONE = 32'd1;
  localparam logic [31:0] CNT_TWO = 32'd2;
`else
  localparam logic [31:0] CNT_ONE = 32'd0;
  localparam logic [31:0] CNT_TWO = 32'd0;
`endif

  logic                     clk_i;
  logic                     rst_i;
  logic [IW-1:0]            gnt_idx_o;
  logic                     busy_o;
  logic                     proto_err_o;
  logic [NH-1:0][CW-1:0]    gnt_cnt_o;

  int n_tests;
  int n_fail;

  caliptra_tlul_host_arb_if #(.NumHosts(NH)) bus ();

  caliptra_tlul_host_arb #(.NumHosts(NH), .CntW(CW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .tl_bus      (bus),
    .gnt_idx_o   (gnt_idx_o),
    .busy_o      (busy_o),
    .proto_err_o (proto_err_o),
    .gnt_cnt_o   (gnt_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic host_req(input int h, input logic v);
    bus.tl_h_i[h].a_valid   = v;
    bus.tl_h_i[h].a_opcode  = OpGet;
    bus.tl_h_i[h].a_address = 32'h1000 * (h + 1);
    bus.tl_h_i[h].a_source  = 8'(h);
    bus.tl_h_i[h].a_mask    = '1;
  endtask

  initial begin
    int exp_h;
    n_tests = 0;
    n_fail  = 0;
    rst_i      = 1'b1;
    bus.tl_h_i = '0;
    bus.tl_d_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check_eq("rst_busy",     32'(busy_o), 32'd0);
    check_eq("rst_proto",    32'(proto_err_o), 32'd0);
    check_eq("rst_d_avalid", 32'(bus.tl_d_o.a_valid), 32'd0);
    check_eq("rst_d_dready", 32'(bus.tl_d_o.d_ready), 32'd0);
    check_eq("rst_h0_aready", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    check_eq("rst_h0_dvalid", 32'(bus.tl_h_o[0].d_valid), 32'd0);
    check_eq("rst_cnt0",     32'(gnt_cnt_o[0]), 32'd0);

    // Single request from host 1, zero-latency forwarding.
    host_req(1, 1'b1);
    bus.tl_d_i.a_ready = 1'b1;
    #1;
    check_eq("single_d_avalid", 32'(bus.tl_d_o.a_valid), 32'd1);
    check_eq("single_d_addr",   bus.tl_d_o.a_address, 32'h2000);
    check_eq("single_h1_aready", 32'(bus.tl_h_o[1].a_ready), 32'd1);
    check_eq("single_h0_aready", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    check_eq("single_gnt",      32'(gnt_idx_o), 32'd1);
    tick();
    host_req(1, 1'b0);
    bus.tl_h_i[1].d_ready = 1'b1;
    bus.tl_d_i.d_valid    = 1'b1;
    bus.tl_d_i.d_opcode   = OpAccessAckData;
    bus.tl_d_i.d_data     = 32'hCAFE_0001;
    bus.tl_d_i.d_source   = 8'd1;
    #1;
    check_eq("single_rsp_busy",   32'(busy_o), 32'd1);
    check_eq("single_rsp_avalid", 32'(bus.tl_d_o.a_valid), 32'd0);
    check_eq("single_h1_dvalid",  32'(bus.tl_h_o[1].d_valid), 32'd1);
    check_eq("single_h1_ddata",   bus.tl_h_o[1].d_data, 32'hCAFE_0001);
    check_eq("single_h1_dsrc",    32'(bus.tl_h_o[1].d_source), 32'd1);
    check_eq("single_h0_dvalid",  32'(bus.tl_h_o[0].d_valid), 32'd0);
    check_eq("single_d_dready",   32'(bus.tl_d_o.d_ready), 32'd1);
    tick();
    bus.tl_d_i.d_valid    = 1'b0;
    bus.tl_h_i[1].d_ready = 1'b0;
    #1;
    check_eq("single_done_busy", 32'(busy_o), 32'd0);
    check_eq("single_cnt1",      32'(gnt_cnt_o[1]), CNT_ONE);

    // Clear history so contention starts from host 0.
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_eq("rst2_cnt1", 32'(gnt_cnt_o[1]), 32'd0);

    // Contention: all three hosts request continuously.
    for (int h = 0; h < int'(NH); h++) begin
      host_req(h, 1'b1);
      bus.tl_h_i[h].d_ready = 1'b1;
    end
    bus.tl_d_i.a_ready = 1'b1;
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = 32'hD00D_0000;
    #1;
    for (int t = 0; t < 6; t++) begin
      exp_h = t % 3;
      check_eq($sformatf("cont%0d_gnt", t),    32'(gnt_idx_o), 32'(exp_h));
      check_eq($sformatf("cont%0d_addr", t),   bus.tl_d_o.a_address, 32'h1000 * 32'(exp_h + 1));
      check_eq($sformatf("cont%0d_aready", t), 32'(bus.tl_h_o[exp_h].a_ready), 32'd1);
      check_eq($sformatf("cont%0d_idle_dready", t), 32'(bus.tl_d_o.d_ready), 32'd0);
      check_eq($sformatf("cont%0d_idle_dvalid", t), 32'(bus.tl_h_o[exp_h].d_valid), 32'd0);
      tick();
      #1;
      check_eq($sformatf("cont%0d_busy", t),   32'(busy_o), 32'd1);
      check_eq($sformatf("cont%0d_dvalid", t), 32'(bus.tl_h_o[exp_h].d_valid), 32'd1);
      check_eq($sformatf("cont%0d_other_dvalid", t), 32'(bus.tl_h_o[(exp_h + 1) % 3].d_valid), 32'd0);
      check_eq($sformatf("cont%0d_rsp_avalid", t), 32'(bus.tl_d_o.a_valid), 32'd0);
      tick();
      #1;
    end
    for (int h = 0; h < int'(NH); h++) host_req(h, 1'b0);
    check_eq("cont_cnt0", 32'(gnt_cnt_o[0]), CNT_TWO);
    check_eq("cont_cnt1", 32'(gnt_cnt_o[1]), CNT_TWO);
    check_eq("cont_cnt2", 32'(gnt_cnt_o[2]), CNT_TWO);

    // Backpressure: device holds a_ready low for three cycles.
    bus.tl_d_i.a_ready = 1'b0;
    bus.tl_d_i.d_valid = 1'b0;
    host_req(0, 1'b1);
    host_req(1, 1'b1);
    #1;
    check_eq("bp_idle_gnt",    32'(gnt_idx_o), 32'd0);
    check_eq("bp_idle_h0_rdy", 32'(bus.tl_h_o[0].a_ready), 32'd0);
    tick();
    for (int c = 0; c < 2; c++) begin
      #1;
      check_eq($sformatf("bp_hold%0d_busy", c),   32'(busy_o), 32'd1);
      check_eq($sformatf("bp_hold%0d_gnt", c),    32'(gnt_idx_o), 32'd0);
      check_eq($sformatf("bp_hold%0d_avalid", c), 32'(bus.tl_d_o.a_valid), 32'd1);
      check_eq($sformatf("bp_hold%0d_addr", c),   bus.tl_d_o.a_address, 32'h1000);
      check_eq($sformatf("bp_hold%0d_h1_rdy", c), 32'(bus.tl_h_o[1].a_ready), 32'd0);
      tick();
    end
    bus.tl_d_i.a_ready = 1'b1;
    #1;
    check_eq("bp_ack_h0_rdy", 32'(bus.tl_h_o[0].a_ready), 32'd1);
    check_eq("bp_ack_h1_rdy", 32'(bus.tl_h_o[1].a_ready), 32'd0);
    check_eq("bp_ack_gnt",    32'(gnt_idx_o), 32'd0);
    tick();
    bus.tl_d_i.d_valid = 1'b1;
    #1;
    check_eq("bp_rsp_h0_dvalid", 32'(bus.tl_h_o[0].d_valid), 32'd1);
    tick();
    bus.tl_d_i.d_valid = 1'b0;
    #1;
    check_eq("bp_next_gnt", 32'(gnt_idx_o), 32'd1);
    tick();
    bus.tl_d_i.d_valid = 1'b1;
    #1;
    check_eq("bp_h1_rsp_dvalid", 32'(bus.tl_h_o[1].d_valid), 32'd1);
    tick();
    host_req(0, 1'b0);
    host_req(1, 1'b0);
    bus.tl_d_i.d_valid = 1'b0;

    // Response stall: host 2 withholds d_ready for four cycles.
    host_req(2, 1'b1);
    bus.tl_h_i[2].d_ready = 1'b0;
    #1;
    check_eq("stall_gnt", 32'(gnt_idx_o), 32'd2);
    tick();
    host_req(2, 1'b0);
    host_req(0, 1'b1);
    bus.tl_d_i.d_valid = 1'b1;
    bus.tl_d_i.d_data  = 32'hBEEF_0002;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq($sformatf("stall%0d_dready", c), 32'(bus.tl_d_o.d_ready), 32'd0);
      check_eq($sformatf("stall%0d_avalid", c), 32'(bus.tl_d_o.a_valid), 32'd0);
      check_eq($sformatf("stall%0d_ddata", c),  bus.tl_h_o[2].d_data, 32'hBEEF_0002);
      check_eq($sformatf("stall%0d_h0_rdy", c), 32'(bus.tl_h_o[0].a_ready), 32'd0);
      check_eq($sformatf("stall%0d_busy", c),   32'(busy_o), 32'd1);
      tick();
    end
    bus.tl_h_i[2].d_ready = 1'b1;
    #1;
    check_eq("stall_release_dready", 32'(bus.tl_d_o.d_ready), 32'd1);
    tick();
    bus.tl_d_i.d_valid    = 1'b0;
    bus.tl_h_i[2].d_ready = 1'b0;
    bus.tl_d_i.a_ready    = 1'b0;
    #1;
    check_eq("post_stall_gnt",    32'(gnt_idx_o), 32'd0);
    check_eq("post_stall_busy",   32'(busy_o), 32'd0);
    check_eq("post_stall_avalid", 32'(bus.tl_d_o.a_valid), 32'd1);
    tick();

    // Protocol violation: host 0 drops a_valid while held.
    host_req(0, 1'b0);
    #1;
    check_eq("proto_drop_busy",   32'(busy_o), 32'd1);
    check_eq("proto_drop_avalid", 32'(bus.tl_d_o.a_valid), 32'd0);
    check_eq("proto_drop_err",    32'(proto_err_o), 32'd0);
    tick();
    check_eq("proto_err_pulse", 32'(proto_err_o), 32'd1);
    check_eq("proto_idle_busy", 32'(busy_o), 32'd0);
    check_eq("proto_idle_avalid", 32'(bus.tl_d_o.a_valid), 32'd0);
    tick();
    check_eq("proto_err_clear", 32'(proto_err_o), 32'd0);

    // Reset while a response is pending.
    host_req(1, 1'b1);
    bus.tl_d_i.a_ready = 1'b1;
    #1;
    check_eq("rstmid_gnt", 32'(gnt_idx_o), 32'd1);
    tick();
    host_req(1, 1'b0);
    bus.tl_d_i.d_valid    = 1'b1;
    bus.tl_h_i[1].d_ready = 1'b0;
    #1;
    check_eq("rstmid_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    check_eq("rstmid_busy",      32'(busy_o), 32'd0);
    check_eq("rstmid_avalid",    32'(bus.tl_d_o.a_valid), 32'd0);
    check_eq("rstmid_dready",    32'(bus.tl_d_o.d_ready), 32'd0);
    check_eq("rstmid_h1_dvalid", 32'(bus.tl_h_o[1].d_valid), 32'd0);
    check_eq("rstmid_h1_aready", 32'(bus.tl_h_o[1].a_ready), 32'd0);
    check_eq("rstmid_cnt1",      32'(gnt_cnt_o[1]), 32'd0);
    for (int h = 0; h < int'(NH); h++) host_req(h, 1'b1);
    #1;
    check_eq("rstmid_first_gnt", 32'(gnt_idx_o), 32'd0);
    check_eq("rstmid_h0_aready", 32'(bus.tl_h_o[0].a_ready), 32'd1);
    tick();
    for (int h = 0; h < int'(NH); h++) host_req(h, 1'b0);
    bus.tl_d_i = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
